ram_bist_ctrl: RTL and testbench

//   Initiator for the 256x8 single-port RAM: drives its clk/we/addr/data_in and checks data_out.
//   On start, writes a selected data pattern to every address, reads every address back, and reports

---
 rtl/ram_bist_pkg.sv | 16 +
 rtl/ram_bist_patgen.sv | 25 ++
 rtl/ram_bist_ctrl.sv | 113 +++++++++++
 tb/tb_ram_bist_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types for the RAM self-test controller: FSM state encoding and pattern select codes.
package ram_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    localparam logic [1:0] PAT_CHECK = 2'd0;
    localparam logic [1:0] PAT_ADDR  = 2'd1;
    localparam logic [1:0] PAT_NADDR = 2'd2;
    localparam logic [1:0] PAT_WALK1 = 2'd3;

endpackage

// File: rtl/ram_bist_patgen.sv
// Pattern generator: combinational (pat_sel, addr) -> expected data, zero latency.
// No flow control; output follows inputs in the same cycle.
module ram_bist_patgen
    import ram_bist_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic [1:0]    pat_sel_i,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (pat_sel_i)
            PAT_CHECK: data_o = addr_i[0] ? DW'(8'hAA) : DW'(8'h55);
            PAT_ADDR:  data_o = DW'(addr_i);
            PAT_NADDR: data_o = DW'(~addr_i);
            PAT_WALK1: data_o = DW'(1) << addr_i[2:0];
            default:   data_o = '0;
        endcase
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM self-test initiator: write pattern to every address, read back and compare; 2*2**AW cycles busy.
// No backpressure: the RAM is assumed to accept a write and return read data every cycle.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    pat_sel,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW-1:0] CNT_MAX = '1;

    bist_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [1:0]    pat_q, pat_d;
    logic [AW:0]   err_q, err_d;
    logic [AW-1:0] ferr_q, ferr_d;
    logic [DW-1:0] pat_dat;
    logic          cnt_last;

    // One generator serves both the write data and the read-back compare.
    ram_bist_patgen #(
        .AW (AW),
        .DW (DW)
    ) u_patgen (
        .pat_sel_i (pat_q),
        .addr_i    (cnt_q),
        .data_o    (pat_dat)
    );

    assign cnt_last = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pat_d   = pat_sel;
                    err_d   = '0;
                    ferr_d  = '0;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = pat_dat;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_last) begin
                    state_d = READ;
                end
            end
            READ: begin
                ram_addr = cnt_q;
                if (ram_rdata != pat_dat) begin
                    err_d = err_q + (AW+1)'(1);
                    if (err_q == '0) begin
                        ferr_d = cnt_q;
                    end
                end
                cnt_d = cnt_q + AW'(1);
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= PAT_CHECK;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    assign busy           = (state_q == WRITE) || (state_q == READ);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == '0);
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a 256x8 RAM model and a read-data fault shim.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] pat_sel;
    logic       busy, done, pass, ram_we;
    logic [8:0] err_cnt;
    logic [7:0] first_err_addr, ram_addr, ram_wdata, ram_rdata;

    logic [7:0] mem [256];
    logic       f0_en, f1_en;
    logic [7:0] f0_addr, f0_mask, f1_addr, f1_mask;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.AW(8), .DW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pat_sel        (pat_sel),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    assign ram_rdata = mem[ram_addr]
                     ^ ((f0_en && ram_addr == f0_addr) ? f0_mask : 8'h00)
                     ^ ((f1_en && ram_addr == f1_addr) ? f1_mask : 8'h00);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [1:0] sel, input logic [7:0] a);
        case (sel)
            2'd0:    pat = a[0] ? 8'hAA : 8'h55;
            2'd1:    pat = a;
            2'd2:    pat = ~a;
            default: pat = 8'h01 << a[2:0];
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge of the first busy cycle (just after the accept edge).
    task automatic launch(input logic [1:0] sel, input string tag);
        @(negedge clk);
        start   = 1'b1;
        pat_sel = sel;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy1"}, busy, 1'b1);
        chk({tag, ".we1"},   ram_we, 1'b1);
        chk({tag, ".addr1"}, ram_addr, 8'h00);
        chk({tag, ".wd1"},   ram_wdata, pat(sel, 8'h00));
    endtask

    // Counts busy cycles; optionally pulses start or changes pat_sel at a given cycle.
    task automatic run_out(input int pulse_at, input int newsel_at, input logic [1:0] newsel,
                           output int busy_cyc);
        busy_cyc = 0;
        while (busy && busy_cyc < 2000) begin
            busy_cyc++;
            start = (busy_cyc == pulse_at);
            if (busy_cyc == newsel_at) pat_sel = newsel;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic chk_done(input string tag, input int busy_cyc, input logic exp_pass,
                            input logic [8:0] exp_err, input logic [7:0] exp_first);
        chk({tag, ".cycles"}, busy_cyc, 512);
        chk({tag, ".done"},   done, 1'b1);
        chk({tag, ".pass"},   pass, exp_pass);
        chk({tag, ".err"},    err_cnt, exp_err);
        chk({tag, ".first"},  first_err_addr, exp_first);
        chk({tag, ".we_off"}, ram_we, 1'b0);
        chk({tag, ".wd_off"}, ram_wdata, 8'h00);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pat_sel = 2'd0;
        f0_en = 1'b0; f1_en = 1'b0;
        f0_addr = 8'h00; f0_mask = 8'h00; f1_addr = 8'h00; f1_mask = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        do_reset();
        chk("rst.busy",  busy, 1'b0);
        chk("rst.done",  done, 1'b0);
        chk("rst.pass",  pass, 1'b0);
        chk("rst.err",   err_cnt, 9'd0);
        chk("rst.first", first_err_addr, 8'h00);
        chk("rst.we",    ram_we, 1'b0);
        chk("rst.addr",  ram_addr, 8'h00);
        chk("rst.wd",    ram_wdata, 8'h00);

        // 1: address pattern, clean RAM
        launch(2'd1, "t1");
        run_out(0, 0, 2'd0, cyc);
        chk_done("t1", cyc, 1'b1, 9'd0, 8'h00);
        chk("t1.mem3c", mem[8'h3C], 8'h3C);

        // 2: checkerboard, single-bit fault at 0x10
        f0_en = 1'b1; f0_addr = 8'h10; f0_mask = 8'h01;
        launch(2'd0, "t2");
        run_out(0, 0, 2'd0, cyc);
        chk_done("t2", cyc, 1'b0, 9'd1, 8'h10);
        chk("t2.mem10", mem[8'h10], 8'h55);

        // 3: walking ones, faults at 0x05 and at the last address
        f0_addr = 8'h05; f1_en = 1'b1; f1_addr = 8'hFF; f1_mask = 8'h01;
        launch(2'd3, "t3");
        run_out(0, 0, 2'd0, cyc);
        chk_done("t3", cyc, 1'b0, 9'd2, 8'h05);
        chk("t3.mem05", mem[8'h05], 8'h20);
        f0_en = 1'b0; f1_en = 1'b0;

        // 4: start pulsed mid-run is ignored
        launch(2'd1, "t4");
        run_out(100, 0, 2'd0, cyc);
        chk_done("t4", cyc, 1'b1, 9'd0, 8'h00);

        // 5: reset during READ, then fresh run with inverted address
        f0_en = 1'b1; f0_addr = 8'h02; f0_mask = 8'h01;
        launch(2'd1, "t5a");
        repeat (299) @(negedge clk);
        chk("t5.midbusy", busy, 1'b1);
        chk("t5.miderr",  err_cnt, 9'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5.busy",  busy, 1'b0);
        chk("t5.done",  done, 1'b0);
        chk("t5.err",   err_cnt, 9'd0);
        chk("t5.first", first_err_addr, 8'h00);
        chk("t5.we",    ram_we, 1'b0);
        f0_en = 1'b0;
        launch(2'd2, "t5b");
        run_out(0, 0, 2'd0, cyc);
        chk_done("t5b", cyc, 1'b1, 9'd0, 8'h00);
        chk("t5.mem00", mem[8'h00], 8'hFF);

        // 6: pat_sel change mid-run ignored; back-to-back restart from DONE clears counts
        f0_en = 1'b1; f0_addr = 8'h80; f0_mask = 8'hFF;
        launch(2'd1, "t6a");
        run_out(0, 50, 2'd3, cyc);
        chk_done("t6a", cyc, 1'b0, 9'd1, 8'h80);
        chk("t6.mem3c", mem[8'h3C], 8'h3C);
        chk("t6.mem81", mem[8'h81], 8'h81);
        f0_en = 1'b0;
        launch(2'd1, "t6b");
        chk("t6.clr_err",  err_cnt, 9'd0);
        chk("t6.clr_done", done, 1'b0);
        chk("t6.clr_pass", pass, 1'b0);
        run_out(0, 0, 2'd0, cyc);
        chk_done("t6b", cyc, 1'b1, 9'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
